// File: rtl/checkerboard_pkg.sv
// Shared checkerboard definitions: board geometry, cell encoding and the
// clear-sweep FSM states used by mem_reset and checkerboard_state_ram.
package checkerboard_pkg;

    localparam int unsigned CB_ADDR_W = 6;
    localparam int unsigned CB_DATA_W = 2;
    localparam int unsigned CB_DEPTH  = 64;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BLACK = 2'b01,
        CELL_WHITE = 2'b10
    } cell_e;

    typedef enum logic [1:0] {
        MR_IDLE  = 2'b00,
        MR_CLEAR = 2'b01,
        MR_DONE  = 2'b10
    } mr_state_e;

endpackage : checkerboard_pkg

// File: rtl/mem_reset.sv
// Sweeps FILL into every word of the external state RAM, one write per cycle,
// while en is held; reports done once the last word has been written.
module mem_reset
    import checkerboard_pkg::*;
#(
    parameter int unsigned       ADDR_W = CB_ADDR_W,
    parameter int unsigned       DATA_W = CB_DATA_W,
    parameter int unsigned       DEPTH  = CB_DEPTH,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(CELL_EMPTY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              done
);

    // Terminal compare rather than counter overflow, so DEPTH == 2**ADDR_W works.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mr_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = '0;
        data_d  = FILL;
        done_d  = 1'b0;

        case (state_q)
            MR_IDLE: begin
                if (en) begin
                    state_d = MR_CLEAR;
                    we_d    = 1'b1;
                end
            end
            MR_CLEAR: begin
                // Dropping en abandons the sweep; a later request restarts at 0.
                if (!en) begin
                    state_d = MR_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = MR_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            MR_DONE: begin
                if (en) begin
                    done_d = 1'b1;
                end else begin
                    state_d = MR_IDLE;
                end
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MR_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= FILL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign ram_we   = we_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign done     = done_q;

endmodule : mem_reset

// File: tb/tb_mem_reset.sv
// Bench for mem_reset: an en-run-length reference model, a behavioural RAM on
// the write port, directed sweep/abort/reset scenarios and a randomized phase.
module tb_mem_reset;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 2;
    localparam int unsigned DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          done;

    always #5 clk = ~clk;

    mem_reset #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .FILL   (2'b00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .done     (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] snap [DEPTH];
    int  fill_req  = 0;
    int  fill_ack  = 0;
    int  wr_cnt    = 0;
    int  cyc       = 0;
    bit  prev_we   = 1'b0;
    int  prev_addr = 0;
    int  run_len   = 0;
    bit  cmp_on    = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // External RAM plus write-port monitor: each sweep starts at 0 and steps by 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            cyc++;
            if (fill_req != fill_ack) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem[i]  = DW'($urandom_range(1, 3));
                    snap[i] = mem[i];
                end
                fill_ack = fill_req;
            end
            if (ram_we) begin
                check(int'(ram_addr) == (prev_we ? prev_addr + 1 : 0), "wr_order",
                      int'(ram_addr), prev_we ? prev_addr + 1 : 0);
                check(ram_data == 2'b00, "wr_data", int'(ram_data), 0);
                mem[ram_addr] = ram_data;
                wr_cnt++;
                prev_addr = int'(ram_addr);
            end
            prev_we = ram_we;
        end
    end

    // Reference model: outputs are a function of how many consecutive edges saw en=1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      run_len = 0;
        else if (en)     run_len = (run_len > int'(DEPTH)) ? int'(DEPTH) + 1 : run_len + 1;
        else             run_len = 0;
    end

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            int act, exp_v, mask;
            act = int'({ram_we, ram_addr, ram_data, done});
            if (run_len == 0) begin
                exp_v = 0;
                mask  = 32'h3ff;
            end else if (run_len <= int'(DEPTH)) begin
                exp_v = int'({1'b1, AW'(run_len - 1), 2'b00, 1'b0});
                mask  = 32'h3ff;
            end else begin
                exp_v = int'({1'b0, 6'd0, 2'b00, 1'b1});
                mask  = 32'h201;
            end
            check(((act ^ exp_v) & mask) == 0, "model", act, exp_v);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold en until done is seen or the watchdog budget expires, then drop en.
    task automatic run_to_done(input string name);
        int k;
        en = 1'b1;
        for (k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check(k < 10000, name, k, 10000);
        en = 1'b0;
        tick(2);
    endtask

    initial begin
        int first, dn, wc, k, bad;

        #1 rst_n = 1'b0;
        tick(2);
        check(ram_we == 1'b0, "rst_we", int'(ram_we), 0);
        check(ram_addr == '0, "rst_addr", int'(ram_addr), 0);
        check(ram_data == 2'b00, "rst_data", int'(ram_data), 0);
        check(done == 1'b0, "rst_done", int'(done), 0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        tick(3);

        // Full sweep over randomly filled memory.
        fill_req++;
        tick(2);
        wc = wr_cnt;
        en = 1'b1;
        first = -1;
        dn = -1;
        for (k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (ram_we && first < 0) first = cyc;
            if (done) begin
                dn = cyc;
                break;
            end
        end
        check(dn >= 0, "watchdog", dn, 0);
        check(dn - first == 64, "latency", dn - first, 64);
        check(wr_cnt - wc == 64, "wr_count", wr_cnt - wc, 64);
        repeat (10) begin
            @(negedge clk);
            check(done && !ram_we, "hold_done", int'({done, ram_we}), 2);
        end
        en = 1'b0;
        @(negedge clk);
        check(done == 1'b0, "done_drop", int'(done), 0);
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] != 2'b00) bad++;
        check(bad == 0, "all_clear", bad, 0);
        tick(2);

        // Abort after the write to address 20.
        fill_req++;
        tick(2);
        en = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ram_we && ram_addr == AW'(20)) break;
        end
        check(k < 200, "abort_reach", k, 200);
        en = 1'b0;
        @(negedge clk);
        check(ram_we == 1'b0, "abort_we", int'(ram_we), 0);
        repeat (5) begin
            @(negedge clk);
            check(done == 1'b0, "abort_done", int'(done), 0);
        end
        bad = 0;
        for (int i = 21; i < int'(DEPTH); i++) if (mem[i] != snap[i]) bad++;
        check(bad == 0, "abort_keep", bad, 0);
        bad = 0;
        for (int i = 0; i <= 20; i++) if (mem[i] != 2'b00) bad++;
        check(bad == 0, "abort_cleared", bad, 0);
        en = 1'b1;
        @(negedge clk);
        check(ram_we && ram_addr == '0, "abort_restart", int'({ram_we, ram_addr}), 64);
        run_to_done("abort_watchdog");

        // Asynchronous reset in the middle of a sweep.
        en = 1'b1;
        tick(10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check(int'({ram_we, ram_addr, ram_data, done}) == 0, "async_rst",
              int'({ram_we, ram_addr, ram_data, done}), 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wc = wr_cnt;
        tick(5);
        check(wr_cnt == wc, "rst_no_wr", wr_cnt - wc, 0);
        en = 1'b1;
        @(negedge clk);
        check(ram_we && ram_addr == '0, "rst_restart", int'({ram_we, ram_addr}), 64);
        run_to_done("rst_watchdog");

        // Randomized en with long runs and occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 799) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        en = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_reset

// File: doc/mem_reset.md
MEM_RESET -- requirements
Module: mem_reset

Interface
REQ-001 Parameter ADDR_W, default 6: RAM address width.
REQ-002 Parameter DATA_W, default 2: RAM data width (one checkerboard cell state).
REQ-003 Parameter DEPTH, default 64: number of words cleared; legal range 1 to 2^ADDR_W.
REQ-004 Parameter FILL, default 0: DATA_W-bit value written to every word.
REQ-005 Port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port en, input, 1 bit: level-sensitive request to start or continue a clear sweep.
REQ-008 Port ram_we, output, 1 bit: write strobe to the external state RAM.
REQ-009 Port ram_addr, output, ADDR_W bits: write address to the external state RAM.
REQ-010 Port ram_data, output, DATA_W bits: write data to the external state RAM.
REQ-011 Port done, output, 1 bit: sweep complete.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, CLEAR, DONE; ram_we, ram_addr, ram_data and done SHALL be registered outputs.
REQ-013 IDLE SHALL hold ram_we=0, ram_addr=0, ram_data=FILL, done=0.
REQ-014 IDLE with en=1 at a rising edge SHALL go to CLEAR, with ram_we=1 and ram_addr=0 on the next cycle.
REQ-015 CLEAR SHALL present one write per cycle, ram_addr incrementing by 1 from 0 to DEPTH-1, ram_data=FILL, ram_we=1 throughout.
REQ-016 After the write to DEPTH-1 is presented, the next edge SHALL enter DONE with ram_we=0 and done=1; first write to done high is DEPTH cycles (64 at default).
REQ-017 DONE with en=1 SHALL hold done=1 and issue no writes.
REQ-018 DONE with en=0 at a rising edge SHALL return to IDLE with done=0 on the next cycle.
REQ-019 en=0 during CLEAR SHALL abort: next cycle IDLE, ram_we=0, done stays 0, and memory is partially cleared.
REQ-020 Re-asserting en after an abort or after DONE->IDLE SHALL restart the sweep from address 0.
REQ-021 The address counter SHALL be wide enough to reach DEPTH-1 without wrap; with DEPTH=2^ADDR_W, termination SHALL use the compare-to-DEPTH-1 condition, not counter overflow.
REQ-022 The external RAM is write-synchronous (write on the rising edge when wr_en=1) with asynchronous read; mem_reset SHALL NOT read it.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, ram_we=0, ram_addr=0, ram_data=FILL, done=0, regardless of clk.
REQ-024 Reset asserted mid-CLEAR SHALL abandon the sweep; after release the block SHALL wait in IDLE for en.

Structure
REQ-025 ADDR_W and DATA_W defaults, the board depth (64), the FILL/empty cell encoding (2'b00) and the FSM state encoding SHALL live in a shared checkerboard package also used by checkerboard_state_ram.
REQ-026 mem_reset SHALL be a single module with no sub-modules; checkerboard_state_ram is a sibling block connected at the parent, and the parent muxes the RAM write port between mem_reset and other writers.

Verification
REQ-027 Fill all 64 words with random values, then hold en=1 -> done rises 64 cycles after the first write, and all 64 words read back 0 after en drops.
REQ-028 Monitor the write port during the sweep -> exactly 64 writes, addresses 0..63 in order, data 0, no gaps.
REQ-029 Hold en=1 for 10 cycles after done -> done stays 1 and ram_we stays 0; drop en -> done=0 on the next cycle.
REQ-030 Drop en after the write to address 20 -> ram_we=0 next cycle, done never rises, and addresses 21..63 keep prior data; re-raise en -> the sweep restarts at address 0.
REQ-031 Assert rst_n=0 mid-sweep -> all outputs return to reset values immediately, and no writes occur until en is sampled high after release.
REQ-032 Timeout watchdog: done not seen within 10000 cycles of en -> test failure.
